// File: rtl/alu_recombine_seq.sv
// alu_recombine_seq: rebuilds a dividend from ALU divide outputs as
// quotient*divisor + remainder using a WIDTH-step shift-add multiplier,
// and reports consistency flags alongside the reconstructed value.

// One shift-add step: conditionally add the shifted multiplicand.
module alu_recombine_step #(
  parameter int RW = 8
) (
  input  logic [RW-1:0] acc,
  input  logic [RW-1:0] mcand,
  input  logic          add_en,
  output logic [RW-1:0] acc_nxt
);
  // The sum never exceeds RW bits, so the carry-out is simply dropped.
  always_comb begin
    acc_nxt = acc;
    if (add_en) acc_nxt = acc + mcand;
  end
endmodule

module alu_recombine_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               fits,
  output logic               rem_ok,
  output logic               div_zero
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     cnt;
  logic              dz_q;
  logic              rok_q;
  logic [RW-1:0]     acc_nxt;
  logic              fits_nxt;

  alu_recombine_step #(.RW(RW)) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .add_en  (mplier[0]),
    .acc_nxt (acc_nxt)
  );

  // Value fits a WIDTH-bit dividend when the upper half is empty.
  always_comb begin
    fits_nxt = (acc_nxt[RW-1:WIDTH] == '0);
  end

  // Control FSM and datapath; outputs are registered and only move at
  // the RUN->DONE edge (or on reset), so they hold between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      dz_q     <= 1'b0;
      rok_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      fits     <= 1'b0;
      rem_ok   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= {{WIDTH{1'b0}}, remainder};
            mcand  <= {{WIDTH{1'b0}}, divisor};
            mplier <= quotient;
            cnt    <= '0;
            dz_q   <= (divisor == '0);
            rok_q  <= (remainder < divisor);
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result   <= acc_nxt;
            fits     <= fits_nxt;
            rem_ok   <= rok_q;
            div_zero <= dz_q;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_recombine_seq.sv
// Directed bench for alu_recombine_seq with a scoreboard of expected results.
module tb_alu_recombine_seq;
  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    logic           fits;
    logic           rem_ok;
    logic           div_zero;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   quotient = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   remainder = '0;
  logic           busy, done, fits, rem_ok, div_zero;
  logic [2*W-1:0] result;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  alu_recombine_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .busy(busy), .done(done), .result(result),
    .fits(fits), .rem_ok(rem_ok), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: count busy cycles / done pulses, pop and compare on done.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("fits", 32'(fits), 32'(e.fits));
        chk("rem_ok", 32'(rem_ok), 32'(e.rem_ok));
        chk("div_zero", 32'(div_zero), 32'(e.div_zero));
        chk("latency", 32'(cyc), 32'(start_cyc + W));
        chk("busy_cycles", 32'(busy_cnt), 32'(W));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drive one operation, push its expected outcome.
  task automatic launch(input int q, input int d, input int r, input bit expect_it);
    exp_t e;
    int   v;
    @(negedge clk);
    quotient  = W'(q);
    divisor   = W'(d);
    remainder = W'(r);
    start     = 1'b1;
    v = q * d + r;
    e.res      = (2*W)'(v);
    e.fits     = (v <= (1 << W) - 1);
    e.rem_ok   = (r < d);
    e.div_zero = (d == 0);
    if (expect_it) sb.push_back(e);
    busy_cnt = 0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Wait (bounded) for the next done pulse, then check it is one cycle.
  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt), 32'(d0 + 1));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({fits, rem_ok, div_zero}), 32'd0);
    rst = 1'b0;

    // 1. 5*3+2 = 17
    launch(5, 3, 2, 1'b1);
    wait_done("t1");
    // 2. 3*4+3 = 15, busy exactly 4 cycles, done 1 cycle
    launch(3, 4, 3, 1'b1);
    wait_done("t2");
    // 3. 15*15+15 = 240
    launch(15, 15, 15, 1'b1);
    wait_done("t3");
    // 4. divisor zero
    launch(7, 0, 9, 1'b1);
    wait_done("t4");
    // held stable between operations
    repeat (3) @(negedge clk);
    chk("hold_result", 32'(result), 32'd9);
    chk("hold_div_zero", 32'(div_zero), 32'd1);

    // 5. second start mid-RUN ignored, operands changed mid-run
    launch(2, 2, 0, 1'b1);
    @(negedge clk);
    start = 1'b1; quotient = 4'd15; divisor = 4'd15; remainder = 4'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5");
    begin
      int d0;
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      chk("t5_single_done", 32'(done_cnt), 32'(d0));
      chk("t5_idle_busy", 32'(busy), 32'd0);
    end

    // 6. reset at RUN step 2 aborts
    launch(9, 5, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_no_done", 32'(done_cnt), 32'(d0));
      chk("t6_result_hold", 32'(result), 32'd0);
    end
    launch(1, 1, 1, 1'b1);
    wait_done("t6b");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
